// File: rtl/bus_mem_port.sv
// bus_mem_port: memory-side endpoint of the 16-bit datapath bus.
// Holds MAR/MDR loaded from BUS and runs word read/write cycles against an
// SRAM with a fixed access time of WAIT_CYCLES clocks.
//
// Ports:
//   Clk, Reset             rising-edge clock, asynchronous active-high reset
//   BUS                    shared datapath bus value
//   LD_MAR, LD_MDR         load MAR / MDR from BUS at the next edge
//   MEM_REQ, MEM_WE        start an operation (sampled in IDLE), 1 = write
//   Data_from_SRAM         SRAM read data
//   MAR, MDR               address / data registers (MDR feeds GateMDR)
//   ADDR, Data_to_SRAM     SRAM address and write data, held per operation
//   DRIVE_EN               enables the top-level SRAM data tristate
//   CE_n, OE_n, WE_n       active-low SRAM strobes
//   BUSY, R, ERR           not idle / one-cycle ready / sticky request-while-busy
module bus_mem_port #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] BUS,
  input  logic        LD_MAR,
  input  logic        LD_MDR,
  input  logic        MEM_REQ,
  input  logic        MEM_WE,
  input  logic [15:0] Data_from_SRAM,
  output logic [15:0] MAR,
  output logic [15:0] MDR,
  output logic [15:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  output logic        DRIVE_EN,
  output logic        CE_n,
  output logic        OE_n,
  output logic        WE_n,
  output logic        BUSY,
  output logic        R,
  output logic        ERR
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          we_q;
  logic [DW-1:0] mar_q;
  logic [DW-1:0] mdr_q;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          drive_en_q;
  logic          ce_n_q;
  logic          oe_n_q;
  logic          we_n_q;
  logic          busy_q;
  logic          r_q;
  logic          err_q;

  // True on the edge that ends the last ACCESS cycle of a read.
  logic read_capture_c;
  assign read_capture_c = (state_q == ACCESS) && (cnt_q == '0) && !we_q;

  // State machine, bus registers and registered SRAM strobes.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      mar_q      <= '0;
      mdr_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      drive_en_q <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      r_q        <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // MAR can be reloaded at any time; an in-flight operation uses addr_q.
      if (LD_MAR) mar_q <= BUS;

      // Read capture wins over a coincident LD_MDR.
      if (read_capture_c) mdr_q <= Data_from_SRAM;
      else if (LD_MDR)    mdr_q <= BUS;

      unique case (state_q)
        IDLE: begin
          r_q <= 1'b0;
          if (MEM_REQ) begin
            addr_q     <= mar_q;
            wdata_q    <= mdr_q;
            we_q       <= MEM_WE;
            cnt_q      <= CW'(WAIT_CYCLES - 1);
            state_q    <= ACCESS;
            busy_q     <= 1'b1;
            ce_n_q     <= 1'b0;
            oe_n_q     <= MEM_WE;
            we_n_q     <= !MEM_WE;
            drive_en_q <= MEM_WE;
          end
        end
        ACCESS: begin
          if (MEM_REQ) err_q <= 1'b1;
          if (cnt_q == '0) begin
            state_q    <= DONE;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            drive_en_q <= 1'b0;
            r_q        <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          if (MEM_REQ) err_q <= 1'b1;
          state_q <= IDLE;
          busy_q  <= 1'b0;
          r_q     <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          r_q        <= 1'b0;
          ce_n_q     <= 1'b1;
          oe_n_q     <= 1'b1;
          we_n_q     <= 1'b1;
          drive_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign MAR          = mar_q;
  assign MDR          = mdr_q;
  assign ADDR         = addr_q;
  assign Data_to_SRAM = wdata_q;
  assign DRIVE_EN     = drive_en_q;
  assign CE_n         = ce_n_q;
  assign OE_n         = oe_n_q;
  assign WE_n         = we_n_q;
  assign BUSY         = busy_q;
  assign R            = r_q;
  assign ERR          = err_q;

endmodule
